imem_loader: RTL and testbench

- Hardware counterpart of the bench's instruction-memory backdoor load.
- Accepts a byte stream, least-significant byte first per word, matching the one-byte-per-line hex trace format.
- Assembles 32-bit little-endian words and writes them through the instruction BRAM write port.
- Holds the OoO core in reset during the load, then releases it for a fixed count of cycles later, so the core starts fetching at PC 0.

---
 rtl/ooo_pkg.sv | 18 +
 rtl/imem_loader_byte_packer.sv | 64 ++++++
 rtl/imem_loader.sv | 124 ++++++++++++
 tb/tb_imem_loader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_pkg.sv
// Shared constants and types for the instruction-memory side of the OoO core.
package ooo_pkg;

  localparam int unsigned IMEM_ADDR_W = 9;
  localparam int unsigned IMEM_DEPTH  = 2 ** IMEM_ADDR_W;

  // addi x0,x0,0
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    LOAD,
    HOLD,
    DONE
  } imem_loader_state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Collects a little-endian byte stream into 32-bit words. A word is emitted
// one cycle after its 4th byte, or after a byte marked last (zero-padded).
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        take,
  input  logic [7:0]  data,
  input  logic        last,
  output logic        word_valid,
  output logic [31:0] word,
  output logic        partial
);

  logic [1:0]  lane;
  logic [23:0] low;
  logic [31:0] assembled;

  // Place the incoming byte above the lanes already collected.
  always_comb begin
    assembled = '0;
    unique case (lane)
      2'd0:    assembled = {24'h0, data};
      2'd1:    assembled = {16'h0, data, low[7:0]};
      2'd2:    assembled = {8'h0, data, low[15:0]};
      default: assembled = {data, low};
    endcase
  end

  // Lane counter, collected bytes and the registered word output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane       <= '0;
      low        <= '0;
      word_valid <= 1'b0;
      word       <= '0;
      partial    <= 1'b0;
    end else if (clear) begin
      lane       <= '0;
      low        <= '0;
      word_valid <= 1'b0;
      partial    <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (take) begin
        if (lane == 2'd3 || last) begin
          word_valid <= 1'b1;
          word       <= assembled;
          partial    <= (lane != 2'd3);
          lane       <= '0;
          low        <= '0;
        end else begin
          unique case (lane)
            2'd0:    low[7:0]   <= data;
            2'd1:    low[15:8]  <= data;
            default: low[23:16] <= data;
          endcase
          lane <= lane + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads the instruction BRAM from a byte stream: NOP-fills the whole memory,
// writes the streamed words from address 0, then releases the core reset
// a fixed number of cycles later.
module imem_loader
  import ooo_pkg::*;
#(
  parameter int unsigned ADDR_W   = IMEM_ADDR_W,
  parameter int unsigned DEPTH    = IMEM_DEPTH,
  parameter logic [31:0] NOP_WORD = ooo_pkg::NOP_WORD,
  parameter int unsigned RST_HOLD = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_partial,
  output logic              err_overflow
);

  localparam int unsigned        HOLD_W     = $clog2(RST_HOLD + 1);
  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]    FULL_COUNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RST_HOLD - 1);

  imem_loader_state_e state, state_next;

  logic [ADDR_W-1:0] addr;
  logic [HOLD_W-1:0] hold_cnt;
  logic              take;
  logic              restart;
  logic              full;
  logic              ld_write;
  logic              pk_valid;
  logic              pk_partial;
  logic [31:0]       pk_word;

  assign take     = byte_valid & byte_ready;
  assign restart  = start & ((state == IDLE) | (state == DONE));
  assign full     = (word_count == FULL_COUNT);
  // A completed word arriving with the memory already full is dropped.
  assign ld_write = pk_valid & ~full;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (restart),
    .take       (take),
    .data       (byte_data),
    .last       (byte_last),
    .word_valid (pk_valid),
    .word       (pk_word),
    .partial    (pk_partial)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Sequencing: fill, stream, hold core in reset, run.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start)                 state_next = FILL;
      FILL: if (addr == LAST_ADDR)     state_next = LOAD;
      LOAD: if (take && byte_last)     state_next = HOLD;
      HOLD: if (hold_cnt == HOLD_LAST) state_next = DONE;
      DONE: if (start)                 state_next = FILL;
      default:                         state_next = IDLE;
    endcase
  end

  // Memory port and core control are decoded from registered state.
  always_comb begin
    mem_we    = (state == FILL) | ld_write;
    mem_addr  = addr;
    mem_wdata = (state == FILL) ? NOP_WORD : pk_word;
    core_rst  = (state != DONE);
    done      = (state == DONE);
  end

  // Address, word counter, hold counter, sticky errors and byte_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_ready   <= 1'b0;
      addr         <= '0;
      hold_cnt     <= '0;
      word_count   <= '0;
      err_partial  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      byte_ready <= (state_next == LOAD);
      hold_cnt   <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
      if (restart) begin
        addr         <= '0;
        word_count   <= '0;
        err_partial  <= 1'b0;
        err_overflow <= 1'b0;
      end else if (state == FILL) begin
        addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
      end else if (pk_valid) begin
        if (pk_partial) err_partial <= 1'b1;
        if (full) begin
          err_overflow <= 1'b1;
        end else begin
          word_count <= word_count + 1'b1;
          // Saturate on the last word so the address never wraps to 0.
          if (addr != LAST_ADDR) addr <= addr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int ADDR_W   = 9;
  localparam int DEPTH    = 512;
  localparam int RST_HOLD = 10;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    bit                is_load;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = '0;
  logic              byte_last = 1'b0;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_rst;
  logic              done;
  logic [ADDR_W:0]   word_count;
  logic              err_partial;
  logic              err_overflow;

  wr_t         exp_q[$];
  int          exp_cyc[$];
  logic [31:0] tb_mem [DEPTH];
  logic [31:0] ref_mem[DEPTH];
  int          cyc = 0;
  int          last_hs_cyc = 0;
  int          acc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_nw, exp_wc;
  bit          exp_part, exp_ovf;

  imem_loader #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP),
    .RST_HOLD (RST_HOLD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_last    (byte_last),
    .byte_ready   (byte_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .core_rst     (core_rst),
    .done         (done),
    .word_count   (word_count),
    .err_partial  (err_partial),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finish_now();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  // Monitor: every BRAM write is popped against the expected write queue;
  // stream writes must land exactly one cycle after the completing byte.
  always @(negedge clk) begin
    if (rst) begin
      if (byte_valid && byte_ready) begin
        if ((acc % 4 == 3 || byte_last) && acc / 4 < DEPTH) exp_cyc.push_back(cyc + 1);
        if (byte_last) last_hs_cyc = cyc;
        acc++;
      end
      if (mem_we) begin
        tb_mem[mem_addr] = mem_wdata;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got addr %0d data %h, expected no write", mem_addr, mem_wdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 64'(mem_addr), 64'(e.addr));
          chk("wr_data", 64'(mem_wdata), 64'(e.data));
          if (e.is_load) begin
            if (exp_cyc.size() == 0) chk("wr_latency_missing", 64'(cyc), 64'hFFFF_FFFF);
            else                     chk("wr_latency", 64'(cyc), 64'(exp_cyc.pop_front()));
          end
        end
      end
    end
  end

  // Reference model: whole-memory NOP fill, then the stream chopped into
  // little-endian words, zero-padded, truncated at DEPTH words.
  task automatic build_expect(input byte_q_t b);
    wr_t e;
    logic [31:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      e.addr = ADDR_W'(i); e.data = NOP; e.is_load = 0;
      exp_q.push_back(e);
      ref_mem[i] = NOP;
    end
    exp_nw = (b.size() + 3) / 4;
    for (int k = 0; k < exp_nw; k++) begin
      w = '0;
      for (int j = 0; j < 4; j++)
        if (4 * k + j < b.size()) w[8*j +: 8] = b[4*k+j];
      if (k < DEPTH) begin
        e.addr = ADDR_W'(k); e.data = w; e.is_load = 1;
        exp_q.push_back(e);
        ref_mem[k] = w;
      end
    end
    exp_wc   = (exp_nw < DEPTH) ? exp_nw : DEPTH;
    exp_part = (b.size() % 4) != 0;
    exp_ovf  = exp_nw > DEPTH;
  endtask

  // Called just after a rising edge; returns the cycles taken to transfer.
  task automatic send_byte(input logic [7:0] d, input logic l, output int n);
    logic ok;
    n = 0;
    byte_valid = 1'b1; byte_data = d; byte_last = l;
    do begin
      @(negedge clk); ok = byte_ready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 2000);
    byte_valid = 1'b0; byte_last = 1'b0;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL byte_timeout: got no byte_ready in %0d cycles, expected handshake", n);
      finish_now();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
  endtask

  // gapmode: 0 back-to-back, 1 one idle cycle between bytes, 2 random gaps.
  task automatic run_load(input byte_q_t b, input int gapmode);
    int n, stalls, lim;
    build_expect(b);
    acc = 0;
    exp_cyc.delete();
    pulse_start();
    @(negedge clk);
    chk("start_core_rst", 64'(core_rst), 1);
    chk("start_done", 64'(done), 0);
    chk("start_fill_we", 64'(mem_we), 1);
    chk("start_fill_addr", 64'(mem_addr), 0);
    @(posedge clk); #1;
    stalls = 0;
    for (int i = 0; i < b.size(); i++) begin
      if (i > 0 && gapmode == 1) begin @(posedge clk); #1; end
      if (i > 0 && gapmode == 2) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_byte(b[i], i == b.size() - 1, n);
      if (i > 0 && gapmode == 0 && n != 1) stalls++;
    end
    if (gapmode == 0) chk("ready_no_stall", 64'(stalls), 0);
    @(negedge clk);
    chk("ready_drop_after_last", 64'(byte_ready), 0);
    lim = 0;
    while (core_rst && lim < 100) begin @(negedge clk); lim++; end
    chk("core_rst_released", 64'(core_rst), 0);
    chk("core_rst_release_cycle", 64'(cyc), 64'(last_hs_cyc + 1 + RST_HOLD));
    chk("done", 64'(done), 1);
    chk("word_count", 64'(word_count), 64'(exp_wc));
    chk("err_partial", 64'(err_partial), 64'(exp_part));
    chk("err_overflow", 64'(err_overflow), 64'(exp_ovf));
    chk("writes_outstanding", 64'(exp_q.size()), 0);
    chk("latency_outstanding", 64'(exp_cyc.size()), 0);
    for (int i = 0; i < DEPTH && i <= exp_nw; i++) chk("mem_word", 64'(tb_mem[i]), 64'(ref_mem[i]));
    exp_q.delete();
    exp_cyc.delete();
    @(posedge clk); #1;
  endtask

  function automatic byte_q_t rand_bytes(input int len);
    byte_q_t q;
    for (int i = 0; i < len; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  initial begin
    byte_q_t b;
    int n;
    logic [31:0] w511;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_rst", 64'(core_rst), 1);
    chk("rst_byte_ready", 64'(byte_ready), 0);
    chk("rst_mem_we", 64'(mem_we), 0);
    chk("rst_mem_addr", 64'(mem_addr), 0);
    chk("rst_mem_wdata", 64'(mem_wdata), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_word_count", 64'(word_count), 0);
    chk("rst_err_partial", 64'(err_partial), 0);
    chk("rst_err_overflow", 64'(err_overflow), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    b = {8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(b, 0);
    chk("basic_mem0", 64'(tb_mem[0]), 64'h0050_0013);
    chk("basic_mem1", 64'(tb_mem[1]), 64'h0010_0093);
    chk("basic_word_count", 64'(word_count), 2);

    run_load(b, 1);
    chk("toggle_mem0", 64'(tb_mem[0]), 64'h0050_0013);
    chk("toggle_mem1", 64'(tb_mem[1]), 64'h0010_0093);
    chk("toggle_word_count", 64'(word_count), 2);

    b = rand_bytes(4);
    b.push_back(8'hAA);
    b.push_back(8'hBB);
    run_load(b, 0);
    chk("partial_mem1", 64'(tb_mem[1]), 64'h0000_BBAA);
    chk("partial_flag", 64'(err_partial), 1);
    chk("partial_word_count", 64'(word_count), 2);

    b = {8'h5A};
    run_load(b, 2);
    chk("single_byte_mem0", 64'(tb_mem[0]), 64'h0000_005A);

    for (int t = 0; t < 4; t++) run_load(rand_bytes($urandom_range(1, 40)), 2);

    b = rand_bytes(DEPTH * 4 + 4);
    w511 = {b[4*511+3], b[4*511+2], b[4*511+1], b[4*511]};
    run_load(b, 0);
    chk("overflow_mem511", 64'(tb_mem[DEPTH-1]), 64'(w511));
    chk("overflow_flag", 64'(err_overflow), 1);
    chk("overflow_word_count", 64'(word_count), 64'(DEPTH));

    // Reset in the middle of LOAD, two bytes into word 5.
    b = rand_bytes(40);
    build_expect(b);
    acc = 0;
    exp_cyc.delete();
    pulse_start();
    for (int i = 0; i < 22; i++) send_byte(b[i], 1'b0, n);
    chk("pre_reset_word_count", 64'(word_count), 5);
    chk("pre_reset_ready", 64'(byte_ready), 1);
    rst = 1'b0;
    #1;
    chk("async_core_rst", 64'(core_rst), 1);
    chk("async_byte_ready", 64'(byte_ready), 0);
    chk("async_word_count", 64'(word_count), 0);
    chk("async_mem_we", 64'(mem_we), 0);
    chk("async_done", 64'(done), 0);
    exp_q.delete();
    exp_cyc.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_load(rand_bytes($urandom_range(8, 30)), 0);

    finish_now();
  end

endmodule
